jtkicker_prog_remap: RTL and testbench

JTKICKER_PROG_REMAP -- requirements
Module: jtkicker_prog_remap

---
 rtl/jtkicker_prog_remap.sv | 165 ++++++++++++++++
 tb/tb_jtkicker_prog_remap.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_prog_remap.sv
// Remaps ROM download bytes into SDRAM programming writes.
// Latency: prog_we rises 2 cycles after an accepted ioctl_wr (one register stage, then the FIFO).
// Backpressure: the FIFO head is held while prog_rdy=0; strobes that arrive while full are dropped and flagged on overflow.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   downloading         ROM download in progress; its edges drive the IDLE/LOAD/DRAIN FSM
//   ioctl_addr/dout/wr  download byte address, data and single-cycle write strobe
//   prog_addr/data/we   remapped SDRAM write, held until prog_rdy accepts it
//   region              region index of the entry currently on prog_addr
//   full                stage 1 plus the FIFO hold 2**DW entries
//   overflow            sticky: a strobe was dropped (cleared by reset or a new download)
//   done                one-cycle pulse when a finished download has fully drained
module jtkicker_prog_remap #(
  parameter int                    AW      = 22,
  parameter int                    REGIONS = 4,
  parameter logic [AW*REGIONS-1:0] STARTS  = {22'h01_8000, 22'h01_0000, 22'h00_8000, 22'h00_0000},
  parameter logic [2*REGIONS-1:0]  MODES   = '0,
  parameter int                    DW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic [AW-1:0] prog_addr,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic [2:0]    region,
  output logic          full,
  output logic          overflow,
  output logic          done
);

  localparam int DEPTH = 1 << DW;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t state_q, state_d;

  // Address/data remap of the incoming byte
  logic [AW-1:0] map_addr;
  logic [7:0]    map_data;
  logic [2:0]    map_region;
  logic [1:0]    map_mode;

  always_comb begin
    map_region = 3'd0;
    map_mode   = MODES[1:0];
    // Starts are ascending, so the last match is the highest region containing the address.
    // Region 0 also absorbs anything below its own start.
    for (int k = 1; k < REGIONS; k++) begin
      if (ioctl_addr >= STARTS[k*AW +: AW]) begin
        map_region = 3'(k);
        map_mode   = MODES[2*k +: 2];
      end
    end
    map_addr = ioctl_addr;
    map_data = ioctl_dout;
    case (map_mode)
      2'd1:    map_addr[0]   = ~ioctl_addr[0];
      2'd2:    map_addr[4:0] = {ioctl_addr[2:0], ~ioctl_addr[4], ~ioctl_addr[3]};
      2'd3:    map_data      = {ioctl_dout[3:0], ioctl_dout[7:4]};
      default: ;
    endcase
  end

  // Stage 1 and FIFO state
  logic          s1_vld_q;
  logic [AW-1:0] s1_addr_q;
  logic [7:0]    s1_data_q;
  logic [2:0]    s1_reg_q;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [7:0]    mem_data [DEPTH];
  logic [2:0]    mem_reg  [DEPTH];

  logic [DW-1:0] wr_ptr_q, rd_ptr_q;
  logic [DW:0]   cnt_q;
  logic [DW+1:0] occ;
  logic          accept, push, pop;
  logic          dl_q, dl_rise, dl_fall;
  logic          ovf_q;

  // The stage-1 entry is already committed, so it counts toward full; this
  // guarantees the FIFO has room whenever stage 1 pushes.
  assign occ     = {1'b0, cnt_q} + {{(DW+1){1'b0}}, s1_vld_q};
  assign full    = (occ == (DW+2)'(DEPTH));
  assign accept  = ioctl_wr & ~full;
  assign push    = s1_vld_q;
  assign prog_we = (cnt_q != '0);
  assign pop     = prog_we & prog_rdy;
  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_reg_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      dl_q      <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_addr_q <= map_addr;
        s1_data_q <= map_data;
        s1_reg_q  <= map_region;
      end
      if (push) wr_ptr_q <= wr_ptr_q + DW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + DW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (DW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (DW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      dl_q <= downloading;
      // A drop in the same cycle as a new download start stays visible.
      if (ioctl_wr & full) ovf_q <= 1'b1;
      else if (dl_rise)    ovf_q <= 1'b0;
      state_q <= state_d;
    end
  end

  // Storage needs no reset: outputs are gated by prog_we below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= s1_addr_q;
      mem_data[wr_ptr_q] <= s1_data_q;
      mem_reg[wr_ptr_q]  <= s1_reg_q;
    end
  end

  assign prog_addr = prog_we ? mem_addr[rd_ptr_q] : '0;
  assign prog_data = prog_we ? mem_data[rd_ptr_q] : '0;
  assign region    = prog_we ? mem_reg[rd_ptr_q]  : '0;
  assign overflow  = ovf_q;

  // Download FSM
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (dl_rise) state_d = LOAD;
      LOAD:  if (dl_fall) state_d = DRAIN;
      DRAIN: begin
        if (dl_rise) begin
          state_d = LOAD;
        end else if (!s1_vld_q && cnt_q == '0) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtkicker_prog_remap.sv
`timescale 1ns/1ps
module tb_jtkicker_prog_remap;
  localparam int AW = 22;
  localparam int REGIONS = 4;
  localparam int DW = 2;
  localparam int DEPTH = 4;
  localparam logic [AW*REGIONS-1:0] STARTS = {22'h00C000, 22'h008000, 22'h004000, 22'h000000};
  localparam logic [2*REGIONS-1:0]  MODES  = {2'd3, 2'd2, 2'd1, 2'd0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          downloading = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wr = 1'b0;
  logic          prog_rdy = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          prog_we;
  logic [2:0]    region;
  logic          full, overflow, done;

  jtkicker_prog_remap #(.AW(AW), .REGIONS(REGIONS), .STARTS(STARTS), .MODES(MODES), .DW(DW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_we(prog_we), .prog_rdy(prog_rdy), .region(region), .full(full),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [2:0]    rgn;
    logic          full;
    logic          ovf;
    logic          done;
  } obs_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [2:0]    rgn;
    int            t;
  } ent_t;

  // Reference model state: every accepted byte not yet written, in order
  ent_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_ovf = 0;
  bit   m_dl_prev = 0;
  int   m_state = 0;  // 0 idle, 1 loading, 2 draining

  int starts_a[REGIONS] = '{'h0000, 'h4000, 'h8000, 'hC000};
  int modes_a[REGIONS]  = '{0, 1, 2, 3};

  function automatic ent_t ref_map(input logic [AW-1:0] a, input logic [7:0] d);
    ent_t e;
    int r = 0;
    int ai = int'(a);
    int di = int'(d);
    int low;
    for (int k = 0; k < REGIONS; k++) if (ai >= starts_a[k]) r = k;
    e.addr = a;
    e.data = d;
    e.rgn  = 3'(r);
    e.t    = 0;
    case (modes_a[r])
      1: e.addr = AW'(ai ^ 1);
      2: begin
        low = ((ai & 7) << 2) | ((((ai >> 4) & 1) ^ 1) << 1) | (((ai >> 3) & 1) ^ 1);
        e.addr = AW'((ai & ~31) | low);
      end
      3: e.data = 8'(((di & 15) << 4) | (di >> 4));
      default: ;
    endcase
    return e;
  endfunction

  function automatic string fmt(input obs_t x);
    return $sformatf("we=%0b addr=%h data=%h rgn=%0d full=%0b ovf=%0b done=%0b",
                     x.we, x.addr, x.data, x.rgn, x.full, x.ovf, x.done);
  endfunction

  // Drives one cycle of stimulus, returns what the DUT showed and what the model predicts.
  task automatic run_cycle(input bit wr, input logic [AW-1:0] a, input logic [7:0] d,
                           input bit rdy, input bit dl, output obs_t o, output obs_t e);
    bit   rise, fall, was_empty;
    ent_t n;
    ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d; prog_rdy = rdy; downloading = dl;
    rise = dl && !m_dl_prev;
    fall = !dl && m_dl_prev;
    was_empty = (q.size() == 0);
    e = '0;
    e.we = (q.size() > 0) && (q[0].t <= cyc);
    if (e.we) begin
      e.addr = q[0].addr; e.data = q[0].data; e.rgn = q[0].rgn;
    end
    e.full = (q.size() == DEPTH);
    e.ovf  = m_ovf;
    e.done = (m_state == 2) && !rise && was_empty;
    @(negedge clk);
    o = '0;
    o.we = prog_we;
    if (e.we) begin
      o.addr = prog_addr; o.data = prog_data; o.rgn = region;
    end
    o.full = full; o.ovf = overflow; o.done = done;
    @(posedge clk);
    if (e.we && rdy) void'(q.pop_front());
    if (wr && !e.full) begin
      n = ref_map(a, d);
      n.t = cyc + 2;
      q.push_back(n);
    end
    if (wr && e.full) m_ovf = 1;
    else if (rise)    m_ovf = 0;
    if (rise)                            m_state = 1;
    else if (m_state == 1 && fall)       m_state = 2;
    else if (m_state == 2 && was_empty)  m_state = 0;
    m_dl_prev = dl;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    #2;
    o = {prog_we, prog_addr, prog_data, region, full, overflow, done};
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_values got %s required all zero", fmt(o));
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    obs_t o, e;
    int first = -1, cnt = 0;
    logic [AW-1:0] seen_a = '0;
    logic [2:0]    seen_r = '0;
    run_cycle(0, '0, '0, 1, 1, o, e);
    n_cmp++; if (o !== e) begin n_err++; $display("FAIL lat_pre got %s required %s", fmt(o), fmt(e)); end
    run_cycle(1, 22'h004000, 8'hA5, 1, 1, o, e);
    n_cmp++; if (o !== e) begin n_err++; $display("FAIL lat_strobe got %s required %s", fmt(o), fmt(e)); end
    for (int k = 1; k <= 5; k++) begin
      run_cycle(0, '0, '0, 1, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL lat_model k=%0d got %s required %s", k, fmt(o), fmt(e)); end
      if (o.we) begin
        cnt++;
        if (first < 0) begin first = k; seen_a = o.addr; seen_r = o.rgn; end
      end
    end
    n_cmp++; if (first !== 2) begin n_err++; $display("FAIL lat_cycles got %0d required 2", first); end
    n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL lat_we_len got %0d required 1", cnt); end
    n_cmp++; if (seen_a !== 22'h004001 || seen_r !== 3'd1)
      begin n_err++; $display("FAIL lat_addr got %h/r%0d required 004001/r1", seen_a, seen_r); end
  endtask

  task automatic test_modes();
    obs_t o, e;
    logic [AW-1:0] da [8] = '{22'h004000, 22'h008018, 22'h008001, 22'h000003, 22'h00C012, 22'h008005, 22'h003FFF, 22'h007FFF};
    logic [7:0]    dd [8] = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'h3C, 8'h66, 8'h5A, 8'h77};
    logic [AW-1:0] xa [8] = '{22'h004001, 22'h008000, 22'h008007, 22'h000003, 22'h00C012, 22'h008017, 22'h003FFF, 22'h007FFE};
    logic [7:0]    xd [8] = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'hC3, 8'h66, 8'h5A, 8'h77};
    logic [2:0]    xr [8] = '{3'd1, 3'd2, 3'd2, 3'd0, 3'd3, 3'd2, 3'd0, 3'd1};
    logic [AW-1:0] ga;
    logic [7:0]    gd;
    logic [2:0]    gr;
    logic [AW-1:0] ra;
    for (int i = 0; i < 8; i++) begin
      ga = '1; gd = '0; gr = '1;
      run_cycle(1, da[i], dd[i], 1, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL mode_model i=%0d got %s required %s", i, fmt(o), fmt(e)); end
      for (int k = 0; k < 3; k++) begin
        run_cycle(0, '0, '0, 1, 1, o, e);
        n_cmp++; if (o !== e) begin n_err++; $display("FAIL mode_model i=%0d got %s required %s", i, fmt(o), fmt(e)); end
        if (o.we) begin ga = o.addr; gd = o.data; gr = o.rgn; end
      end
      n_cmp++;
      if (ga !== xa[i] || gd !== xd[i] || gr !== xr[i]) begin
        n_err++;
        $display("FAIL mode_directed in=%h got %h/%h/r%0d required %h/%h/r%0d", da[i], ga, gd, gr, xa[i], xd[i], xr[i]);
      end
    end
    for (int k = 0; k < 60; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 'hFFFF));
      run_cycle($urandom_range(0, 1) == 1, ra, 8'($urandom), $urandom_range(0, 3) != 0, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL mode_random k=%0d got %s required %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_overflow();
    obs_t o, e;
    int nw = 0;
    for (int k = 0; k < 8; k++) begin
      run_cycle(0, '0, '0, 1, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL ovf_flush got %s required %s", fmt(o), fmt(e)); end
    end
    for (int i = 0; i < 5; i++) begin
      run_cycle(1, AW'(22'h000100 + i), 8'(8'h10 + i), 0, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL ovf_model i=%0d got %s required %s", i, fmt(o), fmt(e)); end
      if (i == 3) begin
        n_cmp++; if (o.full !== 1'b0) begin n_err++; $display("FAIL ovf_full_at4 got %0b required 0", o.full); end
      end
      if (i == 4) begin
        n_cmp++; if (o.full !== 1'b1) begin n_err++; $display("FAIL ovf_full_after4 got %0b required 1", o.full); end
      end
    end
    run_cycle(0, '0, '0, 0, 1, o, e);
    n_cmp++; if (o.ovf !== 1'b1 || o.full !== 1'b1)
      begin n_err++; $display("FAIL ovf_flag got ovf=%0b full=%0b required 1/1", o.ovf, o.full); end
    for (int k = 0; k < 12; k++) begin
      run_cycle(0, '0, '0, 1, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL ovf_drain got %s required %s", fmt(o), fmt(e)); end
      if (o.we) begin
        n_cmp++;
        if (o.addr !== AW'(22'h000100 + nw) || o.data !== 8'(8'h10 + nw))
          begin n_err++; $display("FAIL ovf_order n=%0d got %h/%h required %h/%h", nw, o.addr, o.data, 22'h000100 + nw, 8'h10 + nw); end
        nw++;
      end
    end
    n_cmp++; if (nw !== 4) begin n_err++; $display("FAIL ovf_count got %0d required 4", nw); end
  endtask

  task automatic test_toggle();
    obs_t o, e, p;
    bit   prdy = 1;
    bit   rdy;
    for (int k = 0; k < 4; k++) begin
      run_cycle(0, '0, '0, 1, 0, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL tog_pre got %s required %s", fmt(o), fmt(e)); end
    end
    run_cycle(0, '0, '0, 1, 1, o, e);
    run_cycle(0, '0, '0, 1, 1, o, e);
    n_cmp++; if (o.ovf !== 1'b0) begin n_err++; $display("FAIL tog_ovf_clear got %0b required 0", o.ovf); end
    p = '0;
    for (int k = 0; k < 40; k++) begin
      rdy = (k % 2) == 1;
      run_cycle((k % 2) == 0, AW'($urandom_range(0, 'hFFFF)), 8'($urandom), rdy, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL tog_model k=%0d got %s required %s", k, fmt(o), fmt(e)); end
      if (p.we && !prdy) begin
        n_cmp++;
        if (o.addr !== p.addr || o.data !== p.data || o.rgn !== p.rgn)
          begin n_err++; $display("FAIL tog_stall k=%0d got %s required %s", k, fmt(o), fmt(p)); end
      end
      p = o; prdy = rdy;
    end
    run_cycle(0, '0, '0, 1, 1, o, e);
    n_cmp++; if (o.ovf !== 1'b0) begin n_err++; $display("FAIL tog_nodrop got ovf=%0b required 0", o.ovf); end
  endtask

  task automatic test_done();
    obs_t o, e;
    int last_wr = -1, done_k = -1, ndone = 0;
    for (int k = 0; k < 6; k++) run_cycle(0, '0, '0, 1, 1, o, e);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, AW'(22'h000200 + i), 8'($urandom), 0, 1, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL done_fill got %s required %s", fmt(o), fmt(e)); end
    end
    run_cycle(0, '0, '0, 0, 0, o, e);
    n_cmp++; if (o !== e) begin n_err++; $display("FAIL done_fall got %s required %s", fmt(o), fmt(e)); end
    for (int k = 0; k < 15; k++) begin
      run_cycle(0, '0, '0, 1, 0, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL done_model k=%0d got %s required %s", k, fmt(o), fmt(e)); end
      if (o.we) last_wr = k;
      if (o.done) begin ndone++; done_k = k; end
    end
    n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL done_pulses got %0d required 1", ndone); end
    n_cmp++; if (done_k !== last_wr + 1) begin n_err++; $display("FAIL done_timing got %0d required %0d", done_k, last_wr + 1); end
  endtask

  task automatic test_random();
    obs_t o, e;
    bit dl = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) dl = !dl;
      run_cycle($urandom_range(0, 1) == 1, AW'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, dl, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL rand_model k=%0d got %s required %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int nwe = 0;
    for (int k = 0; k < 8; k++) run_cycle(0, '0, '0, 1, 0, o, e);
    run_cycle(0, '0, '0, 0, 1, o, e);
    run_cycle(1, 22'h000300, 8'h01, 0, 1, o, e);
    run_cycle(1, 22'h000301, 8'h02, 0, 1, o, e);
    run_cycle(0, '0, '0, 0, 1, o, e);
    run_cycle(0, '0, '0, 0, 1, o, e);
    n_cmp++; if (o.we !== 1'b1) begin n_err++; $display("FAIL rstmid_pending got we=%0b required 1", o.we); end
    ioctl_wr = 0; downloading = 0; prog_rdy = 0;
    rst = 1'b1;
    #1;
    n_cmp++; if (prog_we !== 1'b0 || full !== 1'b0 || overflow !== 1'b0)
      begin n_err++; $display("FAIL rstmid_async got we=%0b full=%0b ovf=%0b required 0/0/0", prog_we, full, overflow); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete(); m_ovf = 0; m_state = 0; m_dl_prev = 0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(0, '0, '0, 1, 0, o, e);
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL rstmid_model got %s required %s", fmt(o), fmt(e)); end
      if (o.we) nwe++;
    end
    n_cmp++; if (nwe !== 0) begin n_err++; $display("FAIL rstmid_nowrites got %0d required 0", nwe); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_overflow();
    test_toggle();
    test_done();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
